// File: rtl/pc_redirect_ctrl_if.sv
// Request, stack and PC-redirect signals between the pipeline, the stack port and the
// control-flow sequencer. The master side drives requests; the slave side is the sequencer.
interface pc_redirect_ctrl_if;
  logic        int_req;
  logic        jmp_req;
  logic [31:0] jmp_dst;
  logic        ret_req;
  logic        pipe_stall_in;
  logic [31:0] pc_cur;
  logic [15:0] stk_rdata;
  logic        stk_push;
  logic        stk_pop;
  logic [15:0] stk_wdata;
  logic        pc_int;
  logic        pc_jmp;
  logic        pc_jwsp;
  logic [31:0] pc_dst;
  logic [31:0] pc_acc;
  logic        pc_stall;
  logic        flush;

  modport master (
    output int_req, jmp_req, jmp_dst, ret_req, pipe_stall_in, pc_cur, stk_rdata,
    input  stk_push, stk_pop, stk_wdata, pc_int, pc_jmp, pc_jwsp, pc_dst, pc_acc,
           pc_stall, flush
  );

  modport slave (
    input  int_req, jmp_req, jmp_dst, ret_req, pipe_stall_in, pc_cur, stk_rdata,
    output stk_push, stk_pop, stk_wdata, pc_int, pc_jmp, pc_jwsp, pc_dst, pc_acc,
           pc_stall, flush
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Control-flow sequencer: jumps, interrupt entry (two-word return-PC push) and
// RET/RTI (two-word pop). All outputs are registered and reflect the state being entered.
module pc_redirect_ctrl (
  input logic               clk,
  input logic               reset,
  pc_redirect_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_HI  = 3'd1,
    PUSH_LO  = 3'd2,
    INT_GO   = 3'd3,
    POP_LO   = 3'd4,
    POP_HI   = 3'd5,
    POP_WAIT = 3'd6,
    RET_GO   = 3'd7
  } state_t;

  state_t      state_r;
  logic        int_pend_r;
  logic [31:0] saved_pc_r;
  logic [15:0] ret_lo_r;

  logic        idle_go_s;
  logic        accept_jmp_s;
  logic        accept_ret_s;
  logic        accept_int_s;

  // Acceptance in IDLE: jump beats return beats a pending interrupt
  assign idle_go_s    = (state_r == IDLE) && !bus.pipe_stall_in;
  assign accept_jmp_s = idle_go_s && bus.jmp_req;
  assign accept_ret_s = idle_go_s && !bus.jmp_req && bus.ret_req;
  assign accept_int_s = idle_go_s && !bus.jmp_req && !bus.ret_req && int_pend_r;

  // Sequencer state, pending interrupt and registered redirect/stack outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      int_pend_r    <= 1'b0;
      saved_pc_r    <= 32'h0000_0000;
      ret_lo_r      <= 16'h0000;
      bus.stk_push  <= 1'b0;
      bus.stk_pop   <= 1'b0;
      bus.stk_wdata <= 16'h0000;
      bus.pc_int    <= 1'b0;
      bus.pc_jmp    <= 1'b0;
      bus.pc_jwsp   <= 1'b0;
      bus.pc_dst    <= 32'h0000_0000;
      bus.pc_acc    <= 32'h0000_0000;
      bus.pc_stall  <= 1'b0;
      bus.flush     <= 1'b0;
    end else begin
      bus.stk_push  <= 1'b0;
      bus.stk_pop   <= 1'b0;
      bus.stk_wdata <= 16'h0000;
      bus.pc_int    <= 1'b0;
      bus.pc_jmp    <= 1'b0;
      bus.pc_jwsp   <= 1'b0;
      bus.flush     <= 1'b0;
      bus.pc_stall  <= bus.pipe_stall_in;
      // A new request wins over a same-cycle clear
      int_pend_r    <= bus.int_req | (int_pend_r & ~accept_int_s);
      case (state_r)
        IDLE: begin
          if (accept_jmp_s) begin
            bus.pc_jmp <= 1'b1;
            bus.pc_dst <= bus.jmp_dst;
            bus.flush  <= 1'b1;
            state_r    <= IDLE;
          end else if (accept_ret_s) begin
            bus.stk_pop  <= 1'b1;
            bus.pc_stall <= 1'b1;
            state_r      <= POP_LO;
          end else if (accept_int_s) begin
            saved_pc_r    <= bus.pc_cur;
            bus.stk_push  <= 1'b1;
            bus.stk_wdata <= bus.pc_cur[31:16];
            bus.pc_stall  <= 1'b1;
            state_r       <= PUSH_HI;
          end else begin
            state_r <= IDLE;
          end
        end
        PUSH_HI: begin
          bus.stk_push  <= 1'b1;
          bus.stk_wdata <= saved_pc_r[15:0];
          bus.pc_stall  <= 1'b1;
          state_r       <= PUSH_LO;
        end
        PUSH_LO: begin
          bus.pc_int <= 1'b1;
          bus.flush  <= 1'b1;
          state_r    <= INT_GO;
        end
        INT_GO: begin
          state_r <= IDLE;
        end
        POP_LO: begin
          bus.stk_pop  <= 1'b1;
          bus.pc_stall <= 1'b1;
          state_r      <= POP_HI;
        end
        POP_HI: begin
          // Low word answers the first pop
          ret_lo_r     <= bus.stk_rdata;
          bus.pc_stall <= 1'b1;
          state_r      <= POP_WAIT;
        end
        POP_WAIT: begin
          bus.pc_acc  <= {bus.stk_rdata, ret_lo_r};
          bus.pc_jwsp <= 1'b1;
          bus.flush   <= 1'b1;
          state_r     <= RET_GO;
        end
        RET_GO: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench: directed scenarios then random traffic, checked every cycle
// against a timeline model that schedules each accepted request's output events.
module tb_pc_redirect_ctrl;

  localparam int MAXC = 1024;

  logic clk;
  logic reset;
  pc_redirect_ctrl_if bus ();

  pc_redirect_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Timeline model: expected outputs per cycle
  bit          e_push[MAXC], e_pop[MAXC], e_int[MAXC], e_jmp[MAXC];
  bit          e_jwsp[MAXC], e_flush[MAXC], e_stall[MAXC];
  bit          dst_set[MAXC], acc_set[MAXC], rst_mark[MAXC];
  logic [15:0] wd_val[MAXC];
  logic [31:0] dst_val[MAXC];
  logic [15:0] rd_hist[MAXC];
  int          acc_from[MAXC];
  int          idle_from = 0;
  bit          pend = 1'b0;
  logic [31:0] m_dst = 32'h0;
  logic [31:0] m_acc = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_eval(input int c, input logic r, input logic ir, input logic jr,
                            input logic [31:0] jd, input logic rr, input logic st,
                            input logic [31:0] pc);
    bit accepted;
    accepted = 1'b0;
    if (r) begin
      for (int k = c + 1; k <= c + 6; k++) begin
        e_push[k] = 0; e_pop[k] = 0; e_int[k] = 0; e_jmp[k] = 0; e_jwsp[k] = 0;
        e_flush[k] = 0; e_stall[k] = 0; dst_set[k] = 0; acc_set[k] = 0;
      end
      rst_mark[c + 1] = 1'b1;
      idle_from = c + 1;
      pend = 1'b0;
    end else begin
      if (st) e_stall[c + 1] = 1'b1;
      if (c >= idle_from && !st) begin
        if (jr) begin
          e_jmp[c + 1] = 1'b1; e_flush[c + 1] = 1'b1;
          dst_set[c + 1] = 1'b1; dst_val[c + 1] = jd;
        end else if (rr) begin
          e_pop[c + 1] = 1'b1; e_pop[c + 2] = 1'b1;
          e_stall[c + 1] = 1'b1; e_stall[c + 2] = 1'b1; e_stall[c + 3] = 1'b1;
          e_jwsp[c + 4] = 1'b1; e_flush[c + 4] = 1'b1;
          acc_set[c + 4] = 1'b1; acc_from[c + 4] = c;
          idle_from = c + 5;
        end else if (pend) begin
          e_push[c + 1] = 1'b1; wd_val[c + 1] = pc[31:16];
          e_push[c + 2] = 1'b1; wd_val[c + 2] = pc[15:0];
          e_stall[c + 1] = 1'b1; e_stall[c + 2] = 1'b1;
          e_int[c + 3] = 1'b1; e_flush[c + 3] = 1'b1;
          idle_from = c + 4;
          accepted = 1'b1;
        end
      end
      pend = ir | (pend & !accepted);
    end
  endtask

  task automatic check_all();
    if (rst_mark[cyc]) begin m_dst = 32'h0; m_acc = 32'h0; end
    if (dst_set[cyc]) m_dst = dst_val[cyc];
    if (acc_set[cyc]) m_acc = {rd_hist[acc_from[cyc] + 3], rd_hist[acc_from[cyc] + 2]};
    chk("stk_push", {31'h0, bus.stk_push}, {31'h0, e_push[cyc]});
    chk("stk_pop",  {31'h0, bus.stk_pop},  {31'h0, e_pop[cyc]});
    chk("pc_int",   {31'h0, bus.pc_int},   {31'h0, e_int[cyc]});
    chk("pc_jmp",   {31'h0, bus.pc_jmp},   {31'h0, e_jmp[cyc]});
    chk("pc_jwsp",  {31'h0, bus.pc_jwsp},  {31'h0, e_jwsp[cyc]});
    chk("flush",    {31'h0, bus.flush},    {31'h0, e_flush[cyc]});
    chk("pc_stall", {31'h0, bus.pc_stall}, {31'h0, e_stall[cyc]});
    chk("pc_dst",   bus.pc_dst, m_dst);
    chk("pc_acc",   bus.pc_acc, m_acc);
    if (e_push[cyc]) chk("stk_wdata", {16'h0, bus.stk_wdata}, {16'h0, wd_val[cyc]});
  endtask

  // One cycle: drive at the falling edge, let the rising edge pass, check at the next fall
  task automatic step(input logic r, input logic ir, input logic jr, input logic [31:0] jd,
                      input logic rr, input logic st, input logic [31:0] pc,
                      input logic [15:0] rd);
    reset             = r;
    bus.int_req       = ir;
    bus.jmp_req       = jr;
    bus.jmp_dst       = jd;
    bus.ret_req       = rr;
    bus.pipe_stall_in = st;
    bus.pc_cur        = pc;
    bus.stk_rdata     = rd;
    rd_hist[cyc]      = rd;
    model_eval(cyc, r, ir, jr, jd, rr, st, pc);
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic idle(input int n, input logic [31:0] pc);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, pc, 16'h0);
  endtask

  initial begin
    reset = 1'b1;
    bus.int_req = 1'b0; bus.jmp_req = 1'b0; bus.jmp_dst = 32'h0; bus.ret_req = 1'b0;
    bus.pipe_stall_in = 1'b0; bus.pc_cur = 32'h0; bus.stk_rdata = 16'h0;
    @(negedge clk);

    // Reset state
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 32'h1234, 1'b1, 1'b1, 32'h0, 16'h0);
    chk("rst_pc_dst", bus.pc_dst, 32'h0);

    // Jump
    step(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h10, 16'h0);
    chk("jmp_strobe", {31'h0, bus.pc_jmp}, 32'h1);
    chk("jmp_dst", bus.pc_dst, 32'h0000_0040);
    idle(2, 32'h40);
    chk("jmp_single", {31'h0, bus.pc_jmp}, 32'h0);

    // Interrupt pulse in IDLE: pend registers, acceptance next cycle
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0001_2345, 16'h0);
    idle(1, 32'h0001_2345);
    chk("int_wd_hi", {16'h0, bus.stk_wdata}, 32'h0000_0001);
    idle(1, 32'h0001_2345);
    chk("int_wd_lo", {16'h0, bus.stk_wdata}, 32'h0000_2345);
    idle(1, 32'h0001_2345);
    chk("int_vec", {31'h0, bus.pc_int}, 32'h1);
    idle(2, 32'h0);

    // Return
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 16'hdead);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 16'hbeef);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 16'h2345);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 16'h0001);
    chk("ret_acc", bus.pc_acc, 32'h0001_2345);
    idle(2, 32'h0);

    // Jump and interrupt together: jump first, then push of the post-jump PC
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h50, 16'h0);
    idle(1, 32'h0000_0100);
    chk("ji_wd_hi", {16'h0, bus.stk_wdata}, 32'h0);
    idle(1, 32'h0000_0100);
    chk("ji_wd_lo", {16'h0, bus.stk_wdata}, 32'h0000_0100);
    idle(3, 32'h0000_0100);

    // Interrupt while stalled, then stall released
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0777, 16'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0777, 16'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0777, 16'h0);
    chk("stall_nopush", {31'h0, bus.stk_push}, 32'h0);
    idle(5, 32'h0000_0777);

    // Back-to-back: interrupt arriving mid-return waits for IDLE after RET_GO
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0900, 16'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0900, 16'h1111);
    idle(10, 32'h0000_0900);

    // Reset during POP_HI
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 16'h4444);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 16'h5555);
    chk("rst_mid_pop", {31'h0, bus.stk_pop}, 32'h0);
    idle(5, 32'h0);

    // Random traffic
    for (int k = 0; k < 800; k++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 4) == 0, $urandom(), $urandom_range(0, 7) == 0,
           $urandom_range(0, 4) == 0, $urandom(), 16'($urandom()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Control-flow sequencer that drives the program counter's redirect inputs (interrupt, jump, stack return, stall). It accepts jump, return and interrupt requests from the pipeline. For interrupts it pushes the 32-bit return PC onto the stack as two 16-bit words. For RET/RTI it pops the two words and presents the reassembled address. It sits between the execute/memory stages, the stack port, and the PC register.

## Interface
Parameters:
- none (32-bit PC, 16-bit stack word fixed)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; dominates all other inputs
- int_req  in  1  external interrupt request; sampled every cycle
- jmp_req  in  1  taken jump/branch from execute; 1-cycle pulse
- jmp_dst  in  32  jump target, valid with jmp_req
- ret_req  in  1  RET/RTI from memory stage; 1-cycle pulse
- pipe_stall_in  in  1  hazard-unit stall
- pc_cur  in  32  current PC value; this is the return address saved on interrupt
- stk_rdata  in  16  stack read data, valid the cycle after stk_pop
- stk_push  out  1  push stk_wdata this cycle
- stk_pop  out  1  pop one word this cycle
- stk_wdata  out  16  push data
- pc_int  out  1  force PC to 0 (interrupt vector)
- pc_jmp  out  1  load PC from pc_dst
- pc_jwsp  out  1  load PC from pc_acc
- pc_dst  out  32  jump target
- pc_acc  out  32  popped return address
- pc_stall  out  1  hold PC
- flush  out  1  squash fetch/decode

## Operation
- All outputs are registered.
- Reset value of every output is 0. After reset: state IDLE, int_pend=0, saved_pc=0.
- Reset asserted in any state abandons the sequence. It returns to IDLE and emits no further push or pop.
- int_pend:
  - Set when int_req=1.
  - Cleared only on acceptance. A clear and a set in the same cycle leave it set.
- States: IDLE, PUSH_HI, PUSH_LO, INT_GO, POP_LO, POP_HI, POP_WAIT, RET_GO.
- IDLE, pipe_stall_in=1: accept nothing; stay IDLE. jmp_req and ret_req are dropped, because the upstream stage re-presents them.
- IDLE, pipe_stall_in=0, priority jmp_req > ret_req > int_pend:
  - jmp_req: next cycle pc_jmp=1, pc_dst=jmp_dst, flush=1; stay IDLE. A coincident ret_req is dropped; int_pend is kept.
  - ret_req: go to POP_LO.
  - int_pend, with no jmp_req or ret_req: saved_pc <= pc_cur, clear int_pend, go to PUSH_HI.
- PUSH_HI: stk_push=1, stk_wdata=saved_pc[31:16] → PUSH_LO.
- PUSH_LO: stk_push=1, stk_wdata=saved_pc[15:0] → INT_GO.
- INT_GO: pc_int=1, flush=1 for one cycle → IDLE.
- POP_LO: stk_pop=1 → POP_HI.
- POP_HI: stk_pop=1; capture lo <= stk_rdata → POP_WAIT.
- POP_WAIT: capture hi <= stk_rdata → RET_GO.
- RET_GO: pc_jwsp=1, pc_acc={hi,lo}, flush=1 for one cycle → IDLE.
- pc_stall = pipe_stall_in OR (state ∈ {PUSH_HI, PUSH_LO, POP_LO, POP_HI, POP_WAIT}). It is 0 in INT_GO and RET_GO.
- While not IDLE: jmp_req and ret_req are ignored; int_req still sets int_pend.
- At most one of pc_int / pc_jmp / pc_jwsp is high in any cycle.
- stk_push and stk_pop are never high together.
- pc_dst and pc_acc hold their last value when not strobed.

## Timing
- Jump: request at cycle N → pc_jmp/flush at N+1 (1-cycle latency).
- Interrupt accepted at N:
  - pushes at N+1 (hi) and N+2 (lo)
  - pc_int at N+3
  - back in IDLE at N+4
- Return accepted at N:
  - pops at N+1 and N+2
  - rdata captured at N+2 and N+3
  - pc_jwsp at N+4
  - IDLE at N+5
- A pending interrupt arriving during a return sequence is accepted no earlier than the first IDLE cycle after RET_GO. Back-to-back interrupt/return therefore gives pc_jwsp first, then the push sequence.
- Strobes (pc_int, pc_jmp, pc_jwsp, flush, stk_push, stk_pop) are single-cycle per event. They never extend under pipe_stall_in.

## Test plan
- Reset then jump: jmp_req=1, jmp_dst=0x0000_0040 at N → pc_jmp=1, pc_dst=0x40, flush=1 at N+1 only; pc_stall=0.
- Interrupt: pc_cur=0x0001_2345, int_req pulse in IDLE → stk_wdata 0x0001 then 0x2345 with stk_push; pc_stall high 2 cycles; pc_int=1 at N+3.
- Return: ret_req, stk_rdata=0x2345 at N+2 and 0x0001 at N+3 → pc_jwsp=1, pc_acc=0x0001_2345 at N+4; two stk_pop cycles.
- Simultaneous jmp_req + int_req → jump at N+1. The interrupt push then starts at the following IDLE cycle, saving the post-jump pc_cur.
- pipe_stall_in=1 with int_req pulse → no push while stalled; after stall drops, push sequence starts next cycle.
- reset asserted in POP_HI → next cycle all outputs 0, IDLE, no pc_jwsp ever emitted.
